atm_cash_dispenser: RTL and testbench

- Downstream stage of the ATM controller; consumes an approved withdrawal amount and drives the note-feed mechanism.
- Plans the note mix greedily over four cassettes (200, 100, 50, 10) with limited stock, then fires one feed pulse per note.
- Tracks remaining cassette inventory and reports a completion status back to the controller.

---
 rtl/atm_cash_dispenser_pkg.sv | 43 ++++
 rtl/note_pulse_gen.sv | 65 ++++++
 rtl/atm_cash_dispenser.sv | 166 ++++++++++++++++
 tb/tb_atm_cash_dispenser.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/atm_cash_dispenser_pkg.sv
// Shared definitions for the cash dispenser: denominations, cassette indices,
// completion status codes and dispenser state encodings.
package atm_cash_dispenser_pkg;

  localparam logic [31:0] DENOM_200 = 32'd200;
  localparam logic [31:0] DENOM_100 = 32'd100;
  localparam logic [31:0] DENOM_50  = 32'd50;
  localparam logic [31:0] DENOM_10  = 32'd10;

  localparam logic [1:0] CASS_200 = 2'd0;
  localparam logic [1:0] CASS_100 = 2'd1;
  localparam logic [1:0] CASS_50  = 2'd2;
  localparam logic [1:0] CASS_10  = 2'd3;

  typedef enum logic [2:0] {
    STAT_OK         = 3'd0,
    STAT_BAD_AMOUNT = 3'd1,
    STAT_NO_NOTES   = 3'd2,
    STAT_LIMIT      = 3'd3,
    STAT_JAM        = 3'd4
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_PLAN,
    S_DISPENSE,
    S_DONE
  } disp_state_e;

  function automatic logic [31:0] denom_of(input logic [1:0] idx);
    logic [31:0] val;
    val = DENOM_10;
    case (idx)
      CASS_200: val = DENOM_200;
      CASS_100: val = DENOM_100;
      CASS_50:  val = DENOM_50;
      CASS_10:  val = DENOM_10;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/note_pulse_gen.sv
// Per-note feed timing: PULSE_CYCLES high then GAP_CYCLES low; a new start is
// accepted when idle or on the last gap cycle so notes run back to back.
module note_pulse_gen #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic fire,
  output logic busy,
  output logic phase_first,
  output logic gap_last
);

  typedef enum logic [1:0] {PH_IDLE, PH_PULSE, PH_GAP} phase_e;

  phase_e      phase, next_phase;
  logic [15:0] cnt, next_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= PH_IDLE;
      cnt   <= '0;
    end else begin
      phase <= next_phase;
      cnt   <= next_cnt;
    end
  end

  always_comb begin
    next_phase = phase;
    next_cnt   = cnt;
    if (abort) begin
      next_phase = PH_IDLE;
      next_cnt   = '0;
    end else if (start) begin
      next_phase = PH_PULSE;
      next_cnt   = 16'(PULSE_CYCLES - 1);
    end else begin
      case (phase)
        PH_PULSE: begin
          if (cnt == 16'd0) begin
            next_phase = PH_GAP;
            next_cnt   = 16'(GAP_CYCLES - 1);
          end else begin
            next_cnt = cnt - 16'd1;
          end
        end
        PH_GAP: begin
          if (cnt == 16'd0) next_phase = PH_IDLE;
          else              next_cnt   = cnt - 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign fire        = (phase == PH_PULSE);
  assign busy        = (phase != PH_IDLE);
  assign phase_first = fire && (cnt == 16'(PULSE_CYCLES - 1));
  assign gap_last    = (phase == PH_GAP) && (cnt == 16'd0);

endmodule

// File: rtl/atm_cash_dispenser.sv
// Validates an approved amount, plans a greedy note mix against cassette stock,
// then feeds one pulse per note and reports the outcome with a one-cycle done.
module atm_cash_dispenser
  import atm_cash_dispenser_pkg::*;
#(
  parameter int INIT_NOTES   = 100,
  parameter int MAX_NOTES    = 40,
  parameter int MAX_AMOUNT   = 20000,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_amount,
  output logic        req_ready,
  input  logic        jam,
  input  logic        refill,
  output logic        note_fire,
  output logic [1:0]  note_sel,
  output logic        done,
  output logic [2:0]  status,
  output logic [31:0] dispensed_total,
  output logic [63:0] cass_level
);

  disp_state_e       state, next_state;
  status_e           status_q, next_status;
  logic [31:0]       rem;
  logic [1:0]        d;
  logic [3:0][15:0]  planned;
  logic [3:0][15:0]  level;
  logic [31:0]       total_notes;
  logic [1:0]        sel_q, first_sel;
  logic              handshake, bad_amount, take, notes_left;
  logic              can_start, abort, busy, phase_first, gap_last;

  assign req_ready  = (state == S_IDLE) && !refill;
  assign handshake  = req_valid && req_ready;
  assign bad_amount = (rem == 32'd0) || ((rem % 32'd10) != 32'd0) || (rem > 32'(MAX_AMOUNT));
  assign take       = (state == S_PLAN) && (rem >= denom_of(d)) && (planned[d] < level[d]);
  assign notes_left = (planned != '0);
  assign abort      = (state == S_DISPENSE) && jam;
  assign can_start  = (state == S_DISPENSE) && !jam && notes_left && (!busy || gap_last);

  // Notes leave largest denomination first: lowest cassette index with work left.
  always_comb begin
    first_sel = CASS_10;
    for (int c = 3; c >= 0; c--) begin
      if (planned[c] != 16'd0) first_sel = 2'(c);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      status_q <= STAT_OK;
    end else begin
      state    <= next_state;
      status_q <= next_status;
    end
  end

  always_comb begin
    next_state  = state;
    next_status = status_q;
    case (state)
      S_IDLE: begin
        if (handshake) next_state = S_CHECK;
      end
      S_CHECK: begin
        if (bad_amount) begin
          next_state  = S_DONE;
          next_status = STAT_BAD_AMOUNT;
        end else begin
          next_state = S_PLAN;
        end
      end
      S_PLAN: begin
        if (!take && (d == CASS_10)) begin
          if (rem != 32'd0) begin
            next_state  = S_DONE;
            next_status = STAT_NO_NOTES;
          end else if (total_notes > 32'(MAX_NOTES)) begin
            next_state  = S_DONE;
            next_status = STAT_LIMIT;
          end else begin
            next_state = S_DISPENSE;
          end
        end
      end
      S_DISPENSE: begin
        if (jam) begin
          next_state  = S_DONE;
          next_status = STAT_JAM;
        end else if (!notes_left && (!busy || gap_last)) begin
          next_state  = S_DONE;
          next_status = STAT_OK;
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem             <= '0;
      d               <= '0;
      planned         <= '0;
      total_notes     <= '0;
      level           <= {4{16'(INIT_NOTES)}};
      dispensed_total <= '0;
      sel_q           <= '0;
    end else begin
      if (state == S_IDLE) begin
        if (refill) begin
          level <= {4{16'(INIT_NOTES)}};
        end else if (handshake) begin
          rem             <= req_amount;
          d               <= '0;
          planned         <= '0;
          total_notes     <= '0;
          dispensed_total <= '0;
        end
      end
      if (take) begin
        planned[d]  <= planned[d] + 16'd1;
        rem         <= rem - denom_of(d);
        total_notes <= total_notes + 32'd1;
      end else if ((state == S_PLAN) && (d != CASS_10)) begin
        d <= d + 2'd1;
      end
      if (can_start) begin
        planned[first_sel] <= planned[first_sel] - 16'd1;
        sel_q              <= first_sel;
      end
      // Stock and total are committed when the pulse begins, so a jam later in
      // the same pulse still leaves this note counted.
      if (phase_first) begin
        level[sel_q]    <= level[sel_q] - 16'd1;
        dispensed_total <= dispensed_total + denom_of(sel_q);
      end
    end
  end

  note_pulse_gen #(
    .PULSE_CYCLES(PULSE_CYCLES),
    .GAP_CYCLES  (GAP_CYCLES)
  ) u_pulse (
    .clk        (clk),
    .rst        (rst),
    .start      (can_start),
    .abort      (abort),
    .fire       (note_fire),
    .busy       (busy),
    .phase_first(phase_first),
    .gap_last   (gap_last)
  );

  assign done       = (state == S_DONE);
  assign status     = status_q;
  assign note_sel   = sel_q;
  assign cass_level = level;

endmodule

// File: tb/tb_atm_cash_dispenser.sv
// Directed bench: three dispensers (default, INIT_NOTES=2, MAX_NOTES=3) share
// clock and reset; a negedge monitor logs pulse starts, selects and high cycles.
module tb_atm_cash_dispenser;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid       [3];
  logic [31:0] req_amount      [3];
  logic        req_ready       [3];
  logic        jam             [3];
  logic        refill          [3];
  logic        note_fire       [3];
  logic [1:0]  note_sel        [3];
  logic        done            [3];
  logic [2:0]  status          [3];
  logic [31:0] dispensed_total [3];
  logic [63:0] cass_level      [3];

  atm_cash_dispenser u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_amount(req_amount[0]),
    .req_ready(req_ready[0]), .jam(jam[0]), .refill(refill[0]), .note_fire(note_fire[0]),
    .note_sel(note_sel[0]), .done(done[0]), .status(status[0]),
    .dispensed_total(dispensed_total[0]), .cass_level(cass_level[0]));

  atm_cash_dispenser #(.INIT_NOTES(2)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_amount(req_amount[1]),
    .req_ready(req_ready[1]), .jam(jam[1]), .refill(refill[1]), .note_fire(note_fire[1]),
    .note_sel(note_sel[1]), .done(done[1]), .status(status[1]),
    .dispensed_total(dispensed_total[1]), .cass_level(cass_level[1]));

  atm_cash_dispenser #(.MAX_NOTES(3)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_amount(req_amount[2]),
    .req_ready(req_ready[2]), .jam(jam[2]), .refill(refill[2]), .note_fire(note_fire[2]),
    .note_sel(note_sel[2]), .done(done[2]), .status(status[2]),
    .dispensed_total(dispensed_total[2]), .cass_level(cass_level[2]));

  int         cyc = 0;
  int         pulse_cnt [3] = '{0, 0, 0};
  int         hi_cnt    [3] = '{0, 0, 0};
  logic       fire_prev [3] = '{1'b0, 1'b0, 1'b0};
  logic [1:0] sel_log   [3][64];
  int         rise_cyc  [64];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 3; i++) begin
      if (note_fire[i] && !fire_prev[i]) begin
        sel_log[i][pulse_cnt[i] % 64] <= note_sel[i];
        pulse_cnt[i] <= pulse_cnt[i] + 1;
        if (i == 0) rise_cyc[pulse_cnt[0] % 64] <= cyc;
      end
      if (note_fire[i]) hi_cnt[i] <= hi_cnt[i] + 1;
      fire_prev[i] <= note_fire[i];
    end
  end

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] lv(input int c200, input int c100, input int c50, input int c10);
    return {16'(c10), 16'(c50), 16'(c100), 16'(c200)};
  endfunction

  task automatic send(input int i, input logic [31:0] amt);
    req_amount[i] = amt;
    req_valid[i]  = 1'b1;
    @(negedge clk);
    req_valid[i]  = 1'b0;
  endtask

  task automatic wait_done(input int i, output int n);
    n = 0;
    while (done[i] !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 64'(done[i]), 64'd1);
  endtask

  initial begin
    int n, b, h;
    logic [31:0] bad [3];
    logic [1:0]  es6 [6];
    logic [1:0]  es4 [4];
    bad = '{32'd0, 32'd15, 32'd20010};
    es6 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    es4 = '{2'd0, 2'd0, 2'd1, 2'd1};

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0; req_amount[i] = '0; jam[i] = 1'b0; refill[i] = 1'b0;
    end
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready",  64'(req_ready[0]), 64'd1);
    check("rst_fire",   64'(note_fire[0]), 64'd0);
    check("rst_sel",    64'(note_sel[0]), 64'd0);
    check("rst_done",   64'(done[0]), 64'd0);
    check("rst_status", 64'(status[0]), 64'd0);
    check("rst_total",  64'(dispensed_total[0]), 64'd0);
    check("rst_level0", cass_level[0], lv(100, 100, 100, 100));
    check("rst_level1", cass_level[1], lv(2, 2, 2, 2));
    rst = 1'b1;
    @(negedge clk);

    // 380 -> 200,100,50,10,10,10
    b = pulse_cnt[0]; h = hi_cnt[0];
    send(0, 32'd380);
    wait_done(0, n);
    check("ok_status", 64'(status[0]), 64'd0);
    check("ok_total",  64'(dispensed_total[0]), 64'd380);
    check("ok_level",  cass_level[0], lv(99, 99, 99, 97));
    check("ok_pulses", 64'(pulse_cnt[0] - b), 64'd6);
    check("ok_hi_cycles", 64'(hi_cnt[0] - h), 64'd24);
    for (int k = 0; k < 6; k++) check("ok_sel", 64'(sel_log[0][(b + k) % 64]), 64'(es6[k]));
    for (int k = 0; k < 5; k++)
      check("ok_spacing", 64'(rise_cyc[(b + k + 1) % 64] - rise_cyc[(b + k) % 64]), 64'd6);
    @(negedge clk);
    check("ok_done_1cyc", 64'(done[0]), 64'd0);
    check("ok_ready_back", 64'(req_ready[0]), 64'd1);

    // malformed amounts
    for (int k = 0; k < 3; k++) begin
      b = pulse_cnt[0];
      send(0, bad[k]);
      wait_done(0, n);
      check("bad_latency", 64'(n <= 3), 64'd1);
      check("bad_status", 64'(status[0]), 64'd1);
      check("bad_pulses", 64'(pulse_cnt[0] - b), 64'd0);
      check("bad_total",  64'(dispensed_total[0]), 64'd0);
      check("bad_level",  cass_level[0], lv(99, 99, 99, 97));
      @(negedge clk);
    end

    // jam during third pulse (the 50)
    b = pulse_cnt[0];
    send(0, 32'd380);
    n = 0;
    while ((pulse_cnt[0] - b) < 3 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("jam_reach3", 64'(pulse_cnt[0] - b), 64'd3);
    check("jam_fire_pre", 64'(note_fire[0]), 64'd1);
    jam[0] = 1'b1;
    @(negedge clk);
    jam[0] = 1'b0;
    check("jam_fire_low", 64'(note_fire[0]), 64'd0);
    check("jam_done", 64'(done[0]), 64'd1);
    check("jam_status", 64'(status[0]), 64'd4);
    check("jam_total", 64'(dispensed_total[0]), 64'd350);
    check("jam_level", cass_level[0], lv(98, 98, 98, 97));
    check("jam_pulses", 64'(pulse_cnt[0] - b), 64'd3);
    @(negedge clk);
    check("jam_done_1cyc", 64'(done[0]), 64'd0);

    // INIT_NOTES=2: 600 then 700
    b = pulse_cnt[1];
    send(1, 32'd600);
    wait_done(1, n);
    check("i2_status", 64'(status[1]), 64'd0);
    check("i2_total",  64'(dispensed_total[1]), 64'd600);
    check("i2_level",  cass_level[1], lv(0, 0, 2, 2));
    check("i2_pulses", 64'(pulse_cnt[1] - b), 64'd4);
    for (int k = 0; k < 4; k++) check("i2_sel", 64'(sel_log[1][(b + k) % 64]), 64'(es4[k]));
    @(negedge clk);
    b = pulse_cnt[1];
    send(1, 32'd700);
    wait_done(1, n);
    check("nn_status", 64'(status[1]), 64'd2);
    check("nn_pulses", 64'(pulse_cnt[1] - b), 64'd0);
    check("nn_level",  cass_level[1], lv(0, 0, 2, 2));
    @(negedge clk);

    // MAX_NOTES=3: 380 needs six notes
    b = pulse_cnt[2];
    send(2, 32'd380);
    wait_done(2, n);
    check("lim_status", 64'(status[2]), 64'd3);
    check("lim_pulses", 64'(pulse_cnt[2] - b), 64'd0);
    check("lim_level",  cass_level[2], lv(100, 100, 100, 100));
    @(negedge clk);

    // refill and request together: refill wins, request taken next cycle
    refill[1] = 1'b1; req_valid[1] = 1'b1; req_amount[1] = 32'd600;
    #1 check("rf_ready_low", 64'(req_ready[1]), 64'd0);
    @(negedge clk);
    refill[1] = 1'b0;
    check("rf_level", cass_level[1], lv(2, 2, 2, 2));
    #1 check("rf_ready_high", 64'(req_ready[1]), 64'd1);
    @(negedge clk);
    req_valid[1] = 1'b0;
    b = pulse_cnt[1];
    wait_done(1, n);
    check("rf_status", 64'(status[1]), 64'd0);
    check("rf_total", 64'(dispensed_total[1]), 64'd600);
    check("rf_level_after", cass_level[1], lv(0, 0, 2, 2));
    @(negedge clk);

    // async reset in the middle of a dispense
    b = pulse_cnt[0];
    send(0, 32'd380);
    n = 0;
    while ((pulse_cnt[0] - b) < 1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("mr_started", 64'(pulse_cnt[0] - b), 64'd1);
    rst = 1'b0;
    #1;
    check("mr_fire",   64'(note_fire[0]), 64'd0);
    check("mr_sel",    64'(note_sel[0]), 64'd0);
    check("mr_done",   64'(done[0]), 64'd0);
    check("mr_status", 64'(status[0]), 64'd0);
    check("mr_total",  64'(dispensed_total[0]), 64'd0);
    check("mr_ready",  64'(req_ready[0]), 64'd1);
    check("mr_level0", cass_level[0], lv(100, 100, 100, 100));
    check("mr_level1", cass_level[1], lv(2, 2, 2, 2));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mr_idle_fire", 64'(note_fire[0]), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
